regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have port clk  input  1  meaning sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-008 SHALL have port ready  output  1  meaning init sweep done, ports live.
REQ-009 SHALL have port rd_addr  input  NRD*AW  meaning read addresses, port k at [k*AW +: AW].
REQ-010 SHALL have port rd_data  output  NRD*XLEN  meaning read data, port k at [k*XLEN +: XLEN].
REQ-011 SHALL have port rd_busy  output  NRD  meaning scoreboard pending bit of each read address.
REQ-012 SHALL have port wr_en  input  NWR  meaning per-port write enable.
REQ-013 SHALL have port wr_addr  input  NWR*AW  meaning write addresses.
REQ-014 SHALL have port wr_data  input  NWR*XLEN  meaning write data.
REQ-015 SHALL have port alloc_en  input  1  meaning mark alloc_addr pending (producer issued).
REQ-016 SHALL have port alloc_addr  input  AW  meaning register to mark pending.

Function
REQ-017 SHALL implement a two-state FSM: INIT (sweep counter clears one register per cycle, index 0..NREGS-1) and RUN; INIT->RUN after index NREGS-1 is cleared; ready = (state==RUN), registered.
REQ-018 SHALL make reads combinational: rd_data[k] = regs[rd_addr[k]]; address 0 always reads 0 and is never written or marked busy.
REQ-019 SHALL, in INIT, ignore wr_en and alloc_en, drive all rd_data = 0 and rd_busy = 0.
REQ-020 SHALL, in RUN, commit each wr_en[j] with wr_addr[j]!=0 at the rising edge; when several ports target one address, highest index j wins.
REQ-021 SHALL, when BYPASS=1, return on rd_data[k] the winning same-cycle wr_data for a matching nonzero address; BYPASS=0 returns the pre-edge value.
REQ-022 SHALL set busy[alloc_addr] at the edge when alloc_en (addr!=0); clear busy[a] at the edge when any enabled write targets a.
REQ-023 SHALL give alloc priority over clear when alloc and write hit the same address in one cycle (busy stays 1).
REQ-024 SHALL drive rd_busy[k] = busy[rd_addr[k]] combinationally; with BYPASS=1, rd_busy[k] = 0 when a same-cycle write clears it and no same-cycle alloc sets it.
REQ-025 SHALL treat writes to non-busy registers as legal (no error, busy unchanged).

Reset
REQ-026 SHALL on rst assert (any time, including mid-sweep or mid-write) force state INIT, sweep counter 0, ready 0, all busy bits 0; register contents are don't-care until the sweep rewrites them.
REQ-027 SHALL restart the full NREGS-cycle sweep after rst deasserts; ready rises NREGS cycles after the first edge with rst low.

Structure
REQ-028 SHALL place XLEN/NREGS/NRD/NWR defaults and the state enumeration (INIT, RUN) in shared package regfile_pkg.
REQ-029 SHALL implement the busy-bit array and its set/clear/priority logic in one sub-module regfile_scoreboard; data array, bypass and FSM stay in regfile_mp.

Verification
REQ-030 SHALL cover reset sweep: rst 1->0, NREGS=32 -> ready 0 for 32 cycles, then 1; all reads return 0.
REQ-031 SHALL cover write/read: write 0xDEADBEEF to r5 port 0 -> next cycle rd_data[0]=0xDEADBEEF for rd_addr=5; write to r0 -> r0 still reads 0.
REQ-032 SHALL cover port conflict and bypass: same cycle port0 r7=0x11, port1 r7=0x22, read r7 -> BYPASS=1 shows 0x22 that cycle; r7=0x22 afterwards.
REQ-033 SHALL cover scoreboard: alloc r9 -> rd_busy=1 on r9; write r9 -> cleared; alloc+write r9 same cycle -> busy stays 1.
REQ-034 SHALL cover mid-sweep reset and INIT gating: rst pulse at sweep index 10 -> sweep restarts at 0; write r3=0x55 during INIT -> r3 reads 0 after ready.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and FSM state encoding for the multi-port register file
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;
    typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read, write, alloc and ready signals of the register file
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
) ();
    localparam int AW = $clog2(NREGS);
    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    modport master (
        input  ready, rd_data, rd_busy,
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
    );
    modport slave (
        output ready, rd_data, rd_busy,
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, set by alloc and cleared by writes
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NWR    = NWR_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy, set_v, clr_v;

    // decode this cycle's alloc (set) and write (clear) targets; gated off outside RUN
    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (en) begin
            if (alloc_en && alloc_addr != '0) set_v[alloc_addr] = 1'b1;
            for (int j = 0; j < NWR; j++)
                if (wr_en[j]) clr_v[wr_addr[j*AW +: AW]] = 1'b1;
        end
    end

    // alloc wins over a same-cycle clear; register 0 never becomes pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= (set_v | (busy & ~clr_v)) & ~NREGS'(1);
    end

    // pending lookup per read port, optionally seeing a same-cycle clear early
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++)
            rd_busy[k] = en && busy[rd_addr[k*AW +: AW]] &&
                !(BYPASS != 0 && clr_v[rd_addr[k*AW +: AW]] && !set_v[rd_addr[k*AW +: AW]]);
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with init sweep, write bypass and scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NWR    = NWR_DEF,
    parameter int BYPASS = 1
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    state_t          state, state_n;
    logic [AW-1:0]   cnt, cnt_n;
    logic [XLEN-1:0] regs [NREGS];
    logic            run;

    assign run       = state == RUN;
    assign bus.ready = run;

    // state and sweep index; reset restarts the sweep from register 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // sweep advances one register per cycle and hands over to RUN after the last one
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == INIT) begin
            cnt_n = cnt + 1'b1;
            if (cnt == AW'(NREGS - 1)) state_n = RUN;
        end
    end

    // data array: cleared by the sweep, then written by ports with the highest index winning
    always_ff @(posedge clk) begin
        if (!run) regs[cnt] <= '0;
        else
            for (int j = 0; j < NWR; j++)
                if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
    end

    // combinational reads; r0 and the whole INIT phase read as zero
    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRD; k++)
            if (run && bus.rd_addr[k*AW +: AW] != '0) begin
                bus.rd_data[k*XLEN +: XLEN] = regs[bus.rd_addr[k*AW +: AW]];
                if (BYPASS != 0)
                    for (int j = 0; j < NWR; j++)
                        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == bus.rd_addr[k*AW +: AW])
                            bus.rd_data[k*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
            end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .en         (run),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .rd_addr    (bus.rd_addr),
        .rd_busy    (bus.rd_busy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of sweep, read/write, bypass, scoreboard and reset
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr    = '0;
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        bus.rd_addr = {5'd31, 5'd5};
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.ready); end
        checks++;
        if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (bus.ready !== (i == 32)) begin errors++; $display("FAIL sweep_ready edge %0d got %0b want %0b", i, bus.ready, i == 32); end
        end
        checks++;
        if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL swept_rd_data got %h want 0", bus.rd_data); end
        checks++;
        if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL swept_rd_busy got %b want 00", bus.rd_busy); end
    endtask

    task automatic test_write_read();
        idle();
        bus.wr_en   = 2'b01;
        bus.wr_addr = {5'd0, 5'd5};
        bus.wr_data = {32'h0, 32'hDEADBEEF};
        bus.rd_addr = {5'd5, 5'd1};
        #1;
        checks++;
        if (bus.rd_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_r5 got %h want deadbeef", bus.rd_data[63:32]); end
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL r1_zero got %h want 0", bus.rd_data[31:0]); end
        tick();
        idle();
        bus.rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_r5 got %h want deadbeef", bus.rd_data[31:0]); end
        bus.wr_en   = 2'b10;
        bus.wr_addr = {5'd0, 5'd0};
        bus.wr_data = {32'h12345678, 32'h0};
        bus.rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL r0_nobypass got %h want 0", bus.rd_data); end
        tick();
        idle();
        #1;
        checks++;
        if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL r0_after_write got %h want 0", bus.rd_data); end
    endtask

    task automatic test_conflict();
        idle();
        bus.wr_en   = 2'b11;
        bus.wr_addr = {5'd7, 5'd7};
        bus.wr_data = {32'h22, 32'h11};
        bus.rd_addr = {5'd0, 5'd7};
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL conflict_bypass got %h want 22", bus.rd_data[31:0]); end
        tick();
        idle();
        bus.rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (bus.rd_data !== {32'h22, 32'h22}) begin errors++; $display("FAIL conflict_after got %h want 22/22", bus.rd_data); end
        bus.wr_en   = 2'b11;
        bus.wr_addr = {5'd10, 5'd8};
        bus.wr_data = {32'hB, 32'hA};
        tick();
        idle();
        bus.rd_addr = {5'd10, 5'd8};
        #1;
        checks++;
        if (bus.rd_data !== {32'hB, 32'hA}) begin errors++; $display("FAIL dual_write got %h want 0000000b0000000a", bus.rd_data); end
    endtask

    task automatic test_scoreboard();
        idle();
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = 5'd9;
        bus.rd_addr    = {5'd0, 5'd9};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL alloc_before_edge got %b want 0", bus.rd_busy[0]); end
        tick();
        bus.alloc_en = 1'b0;
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL alloc_r9 got %b want 1", bus.rd_busy[0]); end
        bus.wr_en   = 2'b01;
        bus.wr_addr = {5'd0, 5'd9};
        bus.wr_data = {32'h0, 32'h99};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_bypass_clear got %b want 0", bus.rd_busy[0]); end
        tick();
        idle();
        bus.rd_addr = {5'd0, 5'd9};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL write_clears got %b want 0", bus.rd_busy[0]); end
        checks++;
        if (bus.rd_data[31:0] !== 32'h99) begin errors++; $display("FAIL r9_data got %h want 99", bus.rd_data[31:0]); end
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = 5'd9;
        tick();
        bus.wr_en   = 2'b10;
        bus.wr_addr = {5'd9, 5'd0};
        bus.wr_data = {32'h77, 32'h0};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL alloc_write_bypass got %b want 1", bus.rd_busy[0]); end
        tick();
        idle();
        bus.rd_addr = {5'd0, 5'd9};
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL alloc_beats_clear got %b want 1", bus.rd_busy[0]); end
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = 5'd0;
        bus.wr_en      = 2'b01;
        bus.wr_addr    = {5'd0, 5'd4};
        bus.wr_data    = {32'h0, 32'h44};
        tick();
        idle();
        bus.rd_addr = {5'd4, 5'd0};
        #1;
        checks++;
        if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL r0_r4_not_busy got %b want 00", bus.rd_busy); end
    endtask

    task automatic test_midsweep();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (dut.cnt !== 5'd10) begin errors++; $display("FAIL sweep_index got %0d want 10", dut.cnt); end
        rst = 1'b1;
        #1;
        checks++;
        if (dut.cnt !== 5'd0 || bus.ready !== 1'b0) begin errors++; $display("FAIL async_reset cnt %0d ready %0b want 0 0", dut.cnt, bus.ready); end
        tick();
        rst = 1'b0;
        bus.wr_en      = 2'b01;
        bus.wr_addr    = {5'd0, 5'd3};
        bus.wr_data    = {32'h0, 32'h55};
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = 5'd3;
        bus.rd_addr    = {5'd0, 5'd3};
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 32) idle();
            checks++;
            if (bus.ready !== (i == 32)) begin errors++; $display("FAIL resweep_ready edge %0d got %0b want %0b", i, bus.ready, i == 32); end
        end
        bus.rd_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (bus.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL init_write_ignored got %h want 0", bus.rd_data[31:0]); end
        checks++;
        if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL init_alloc_ignored got %b want 0", bus.rd_busy[0]); end
        bus.rd_addr = {5'd5, 5'd9};
        #1;
        checks++;
        if (bus.rd_data !== 64'h0 || bus.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_cleared data %h busy %b want 0 00", bus.rd_data, bus.rd_busy); end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_conflict();
        test_scoreboard();
        test_midsweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
